// File: rtl/procesor_io.sv
// Accumulator core: fetch/exec/mem/io/halt FSM with ROM, RAM and handshaked I/O ports.
// Define PROC_TRAP_EN to make opcode F trap and halt; by default it executes as NOP.
module procesor_io #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RAM_SIZE = 8,
  parameter int unsigned ROM_SIZE = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [ROM_SIZE-1:0] rom_addr_o,
  input  logic [15:0]         instr_i,
  output logic [RAM_SIZE-1:0] ram_addr_o,
  output logic                we_o,
  output logic [DATA_W-1:0]   ram_in_o,
  input  logic [DATA_W-1:0]   ram_out_i,
  input  logic [DATA_W-1:0]   data_in_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [DATA_W-1:0]   data_out_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                halted_o,
  output logic                trap_o
);

  localparam logic [3:0] OpNop = 4'h0, OpLdi = 4'h1, OpLd  = 4'h2, OpSt  = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4, OpSub = 4'h5, OpAnd = 4'h6, OpOr  = 4'h7;
  localparam logic [3:0] OpXor = 4'h8, OpJmp = 4'h9, OpJz  = 4'hA, OpJn  = 4'hB;
  localparam logic [3:0] OpIn  = 4'hC, OpOut = 4'hD, OpHalt = 4'hE;
`ifdef PROC_TRAP_EN
  localparam logic [3:0] OpRsvd = 4'hF;
`endif

  typedef enum logic [2:0] {StFetch, StExec, StMem, StIo, StHalt} state_e;

  state_e              state_q, state_d;
  logic [ROM_SIZE-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [3:0]          ir_op_q, ir_op_d;
  logic [RAM_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                out_valid_q, out_valid_d;
  logic                trap_q, trap_d;

  logic [3:0]          op;
  logic [DATA_W-1:0]   imm;
  logic [RAM_SIZE-1:0] op_addr;
  logic [ROM_SIZE-1:0] jmp_tgt, pc_inc;

  assign op      = instr_i[15:12];
  assign imm     = DATA_W'($signed(instr_i[11:0]));
  assign op_addr = instr_i[RAM_SIZE-1:0];
  assign jmp_tgt = instr_i[ROM_SIZE-1:0];
  assign pc_inc  = pc_q + ROM_SIZE'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    ir_op_d     = ir_op_q;
    ram_addr_d  = ram_addr_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    trap_d      = trap_q;
    ram_addr_o  = ram_addr_q;
    we_o        = 1'b0;
    in_ready_o  = 1'b0;
    case (state_q)
      StFetch: state_d = StExec;
      StExec: begin
        ir_op_d = op;
        pc_d    = pc_inc;
        state_d = StFetch;
        case (op)
          OpLdi: acc_d = imm;
          OpSt: begin
            we_o       = 1'b1;
            ram_addr_o = op_addr;
            ram_addr_d = op_addr;
          end
          OpLd, OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            ram_addr_o = op_addr;
            ram_addr_d = op_addr;
            state_d    = StMem;
          end
          OpJmp: pc_d = jmp_tgt;
          OpJz:  if (acc_q == '0) pc_d = jmp_tgt;
          OpJn:  if (acc_q[DATA_W-1]) pc_d = jmp_tgt;
          // I/O instructions advance the PC only once the transfer completes.
          OpIn: begin
            pc_d    = pc_q;
            state_d = StIo;
          end
          OpOut: begin
            pc_d        = pc_q;
            data_out_d  = acc_q;
            out_valid_d = 1'b1;
            state_d     = StIo;
          end
          OpHalt: state_d = StHalt;
`ifdef PROC_TRAP_EN
          OpRsvd: begin
            pc_d    = pc_q;
            trap_d  = 1'b1;
            state_d = StHalt;
          end
`endif
          default: ;
        endcase
      end
      StMem: begin
        case (ir_op_q)
          OpLd:    acc_d = ram_out_i;
          OpAdd:   acc_d = acc_q + ram_out_i;
          OpSub:   acc_d = acc_q - ram_out_i;
          OpAnd:   acc_d = acc_q & ram_out_i;
          OpOr:    acc_d = acc_q | ram_out_i;
          OpXor:   acc_d = acc_q ^ ram_out_i;
          default: ;
        endcase
        state_d = StFetch;
      end
      StIo: begin
        if (ir_op_q == OpIn) begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            acc_d   = data_in_i;
            pc_d    = pc_inc;
            state_d = StFetch;
          end
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = StFetch;
        end
      end
      StHalt:  ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      acc_q       <= '0;
      ir_op_q     <= OpNop;
      ram_addr_q  <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      ir_op_q     <= ir_op_d;
      ram_addr_q  <= ram_addr_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      trap_q      <= trap_d;
    end
  end

  assign rom_addr_o  = pc_q;
  assign ram_in_o    = acc_q;
  assign data_out_o  = data_out_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = (state_q == StHalt);
  assign trap_o      = trap_q;

endmodule

// File: tb/tb_procesor_io.sv
// Directed bench for procesor_io: programs, handshake stalls, jumps, resets and opcode F.
module tb_procesor_io;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic [7:0]  rom_addr;
  logic [15:0] instr;
  logic [7:0]  ram_addr;
  logic        we;
  logic [15:0] ram_in, ram_out, data_in, data_out;
  logic        in_valid, in_ready, out_valid, out_ready, halted, trap;

  logic [2:0]  rom_addr3;
  logic [15:0] instr3, ram_in3, data_out3;
  logic [7:0]  ram_addr3;
  logic        we3, in_ready3, out_valid3, halted3, trap3;

  logic [15:0] rom  [256];
  logic [15:0] ram  [256];
  logic [15:0] rom3 [8];

  int total = 0;
  int bad   = 0;
  int we_cnt, ov_cnt;
  logic [7:0]  we_addr;
  logic [15:0] ov_data;

  always #5 clk = ~clk;

  procesor_io u_dut (
    .clk_i(clk), .rst_i(rst), .rom_addr_o(rom_addr), .instr_i(instr),
    .ram_addr_o(ram_addr), .we_o(we), .ram_in_o(ram_in), .ram_out_i(ram_out),
    .data_in_i(data_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_out_o(data_out), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .halted_o(halted), .trap_o(trap)
  );

  procesor_io #(.ROM_SIZE(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .rom_addr_o(rom_addr3), .instr_i(instr3),
    .ram_addr_o(ram_addr3), .we_o(we3), .ram_in_o(ram_in3), .ram_out_i(16'h0000),
    .data_in_i(16'h0000), .in_valid_i(1'b0), .in_ready_o(in_ready3),
    .data_out_o(data_out3), .out_valid_o(out_valid3), .out_ready_i(1'b1),
    .halted_o(halted3), .trap_o(trap3)
  );

  // Synchronous ROM/RAM models; the RAM reloads its preset contents on rst.
  always @(posedge clk) begin
    instr   <= rom[rom_addr];
    instr3  <= rom3[rom_addr3];
    ram_out <= ram[ram_addr];
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
      ram[1] <= 16'h00F0;
      ram[2] <= 16'h0F0F;
      ram[9] <= 16'h8000;
    end else if (we) begin
      ram[ram_addr] <= ram_in;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      we_cnt  <= 0;
      ov_cnt  <= 0;
      we_addr <= 8'h00;
      ov_data <= 16'h0000;
    end else begin
      if (we) begin
        we_cnt  <= we_cnt + 1;
        we_addr <= ram_addr;
      end
      if (out_valid) begin
        ov_cnt  <= ov_cnt + 1;
        ov_data <= data_out;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; data_in = 16'h0000;
    for (int i = 0; i < 8; i++) rom3[i] = 16'h0000;
    rom3[0] = 16'h9006;
    rom3[6] = 16'h9007;

    // LDI 5; ST 3; LDI -2; ADD 3; OUT; HALT
    clear_rom();
    rom[0] = 16'h1005; rom[1] = 16'h3003; rom[2] = 16'h1FFE;
    rom[3] = 16'h4003; rom[4] = 16'hD000; rom[5] = 16'hE000;
    do_reset();
    wait_halt(60);
    check("p1_we_count", we_cnt, 1);
    check("p1_we_addr", {24'd0, we_addr}, 32'd3);
    check("p1_ram3", {16'd0, ram[3]}, 32'd5);
    check("p1_out_cycles", ov_cnt, 1);
    check("p1_out_data", {16'd0, ov_data}, 32'h0003);
    check("p1_trap", {31'd0, trap}, 32'd0);

    // Reset values, then IN with a 4-cycle stall
    clear_rom();
    rom[0] = 16'hC000; rom[1] = 16'h3007; rom[2] = 16'hE000;
    do_reset();
    check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_in", {16'd0, ram_in}, 32'd0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("in_wait_ready", {31'd0, in_ready}, 32'd1);
      check("in_wait_pc", {24'd0, rom_addr}, 32'd0);
      tick();
    end
    data_in  = 16'h1234;
    in_valid = 1'b1;
    check("in_xfer_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("in_done_pc", {24'd0, rom_addr}, 32'd1);
    check("in_done_ready", {31'd0, in_ready}, 32'd0);
    check("in_acc", {16'd0, ram_in}, 32'h1234);
    wait_halt(20);
    check("in_ram7", {16'd0, ram[7]}, 32'h1234);

    // OUT with out_ready low for 5 cycles
    clear_rom();
    rom[0] = 16'h107A; rom[1] = 16'hD000; rom[2] = 16'hE000;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("out_hold_valid", {31'd0, out_valid}, 32'd1);
      check("out_hold_data", {16'd0, data_out}, 32'h007A);
      tick();
    end
    out_ready = 1'b1;
    check("out_rel_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("out_cleared", {31'd0, out_valid}, 32'd0);
    check("out_pc", {24'd0, rom_addr}, 32'd2);

    // ALU ops against RAM presets
    clear_rom();
    rom[0] = 16'h10FF; rom[1] = 16'h8001; rom[2] = 16'h3011; rom[3] = 16'h7001;
    rom[4] = 16'h6002; rom[5] = 16'h3012; rom[6] = 16'h5001; rom[7] = 16'h3013;
    rom[8] = 16'h2001; rom[9] = 16'h3014; rom[10] = 16'hE000;
    do_reset();
    wait_halt(80);
    check("alu_xor", {16'd0, ram[8'h11]}, 32'h000F);
    check("alu_or_and", {16'd0, ram[8'h12]}, 32'h000F);
    check("alu_sub", {16'd0, ram[8'h13]}, 32'hFF1F);
    check("alu_ld", {16'd0, ram[8'h14]}, 32'h00F0);

    // JZ taken on 0, JN taken on 0x8000, JZ not taken on 0x8000
    clear_rom();
    rom[0] = 16'h1000; rom[1] = 16'hA005; rom[2] = 16'hE000;
    rom[5] = 16'h2009; rom[6] = 16'hB020; rom[7] = 16'hE000;
    rom[8'h20] = 16'hA030; rom[8'h21] = 16'h3010; rom[8'h22] = 16'hE000;
    rom[8'h30] = 16'hE000;
    do_reset();
    wait_halt(60);
    check("br_ram10", {16'd0, ram[8'h10]}, 32'h8000);
    check("br_final_pc", {24'd0, rom_addr}, 32'h23);

    // PC wrap: 8-bit 0->FE->FF->00 and 3-bit 0->6->7->0
    clear_rom();
    rom[0] = 16'h90FE;
    rst3 = 1'b1;
    do_reset();
    rst3 = 1'b0;
    tick(); tick();
    check("wrap8_fe", {24'd0, rom_addr}, 32'hFE);
    check("wrap3_6", {29'd0, rom_addr3}, 32'd6);
    tick(); tick();
    check("wrap8_ff", {24'd0, rom_addr}, 32'hFF);
    check("wrap3_7", {29'd0, rom_addr3}, 32'd7);
    tick(); tick();
    check("wrap8_00", {24'd0, rom_addr}, 32'h00);
    check("wrap3_0", {29'd0, rom_addr3}, 32'd0);
    check("wrap3_quiet", {29'd0, we3, halted3, trap3}, 32'd0);

    // Reset during an OUT wait, with out_ready rising on the same edge
    clear_rom();
    rom[0] = 16'h107A; rom[1] = 16'hD000; rom[2] = 16'hE000;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("rst_out_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    check("rst_out_valid2", {31'd0, out_valid}, 32'd0);
    check("rst_out_data2", {16'd0, data_out}, 32'd0);
    check("rst_out_pc", {24'd0, rom_addr}, 32'd0);
    tick(); tick();
    check("rst_out_restart", {24'd0, rom_addr}, 32'd1);

    // Reset during MEM of LD 1
    clear_rom();
    rom[0] = 16'h2001; rom[1] = 16'hE000;
    out_ready = 1'b1;
    do_reset();
    tick(); tick();
    check("mem_addr_pre", {24'd0, ram_addr}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mem_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_mem_acc", {16'd0, ram_in}, 32'd0);
    check("rst_mem_pc", {24'd0, rom_addr}, 32'd0);

    // Opcode F at address 2
    clear_rom();
    rom[2] = 16'hF000; rom[3] = 16'hE000;
    do_reset();
    wait_halt(30);
`ifdef PROC_TRAP_EN
    check("opf_trap", {31'd0, trap}, 32'd1);
    check("opf_pc", {24'd0, rom_addr}, 32'd2);
`else
    check("opf_trap", {31'd0, trap}, 32'd0);
    check("opf_pc", {24'd0, rom_addr}, 32'd4);
`endif
    check("opf_in_ready", {31'd0, in_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/procesor_io.md
PROCESOR_IO -- requirements
Module: procesor_io

Interface
REQ-001 DATA_W, 16, accumulator/RAM/IO data width; SHALL be in the range 12..32.
REQ-002 RAM_SIZE, 8, RAM address width; SHALL be in the range 1..12.
REQ-003 ROM_SIZE, 8, ROM address and PC width; SHALL be in the range 1..12.
REQ-004 clk  in  1  single clock; all state SHALL change on the rising edge only.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rom_addr  out  ROM_SIZE  instruction fetch address (equals PC).
REQ-007 instr  in  16  ROM data, valid one cycle after rom_addr is presented.
REQ-008 ram_addr  out  RAM_SIZE  data memory address.
REQ-009 we  out  1  RAM write strobe, asserted for exactly one cycle per ST.
REQ-010 ram_in  out  DATA_W  RAM write data.
REQ-011 ram_out  in  DATA_W  RAM read data, valid one cycle after ram_addr is presented.
REQ-012 data_in  in  DATA_W  input port data.
REQ-013 in_valid  in  1 / in_ready  out  1  input handshake.
REQ-014 data_out  out  DATA_W  output port data, registered.
REQ-015 out_valid  out  1 / out_ready  in  1  output handshake.
REQ-016 halted  out  1  core is stopped; trap  out  1  core stopped on an illegal opcode.

Function
REQ-017 Instruction format: op=instr[15:12]; the operand field is instr[11:0]; addresses are the operand LSBs; imm is the operand sign-extended to DATA_W.
REQ-018 Opcodes SHALL be: 0 NOP, 1 LDI (acc=imm), 2 LD (acc=M), 3 ST (M=acc), 4 ADD, 5 SUB (acc-M), 6 AND, 7 OR, 8 XOR (acc op M), 9 JMP, A JZ (acc==0), B JN (acc[DATA_W-1]), C IN, D OUT, E HALT, F reserved (see REQ-032).
REQ-019 FSM states SHALL be FETCH, EXEC, MEM, IO, HALT; reset state is FETCH.
REQ-020 FETCH: drive rom_addr=PC, then go to EXEC; in EXEC, instr is valid and is latched into the instruction register.
REQ-021 EXEC: execute NOP/LDI/ST/JMP/JZ/JN and return to FETCH, so these take 2 cycles; for LD/ALU ops, issue ram_addr and go to MEM; IN/OUT go to IO; HALT goes to HALT.
REQ-022 MEM: capture ram_out into acc (LD) or acc op ram_out (ALU), then return to FETCH, so these take 3 cycles.
REQ-023 ST SHALL assert we with ram_addr=operand and ram_in=acc in EXEC for one cycle.
REQ-024 PC SHALL increment modulo 2^ROM_SIZE in EXEC; a taken jump SHALL load PC with operand[ROM_SIZE-1:0] instead; PC wrap from all-ones to 0 is legal.
REQ-025 ADD/SUB SHALL wrap modulo 2^DATA_W; no carry is stored.
REQ-026 IN: in_ready=1 only while in IO for IN; on in_valid&&in_ready, acc=data_in, then go to FETCH; if in_valid is already high on IO entry, the transfer SHALL complete in that cycle.
REQ-027 OUT: on EXEC, register data_out=acc and set out_valid; out_valid and data_out SHALL hold stable until out_valid&&out_ready; then clear out_valid and go to FETCH.
REQ-028 HALT: the core SHALL do nothing further; halted=1, we=0, in_ready=0, out_valid=0, until rst.

Reset
REQ-029 rst SHALL abort any state, including mid-handshake: PC=0, acc=0, state=FETCH, we=0, in_ready=0, out_valid=0, data_out=0, halted=0, trap=0, ram_addr=0, ram_in=0.
REQ-030 rst SHALL take priority over every simultaneous event, including handshake completion.

Configuration
REQ-031 The macro PROC_TRAP_EN SHALL select the handling of opcode F.
REQ-032 With PROC_TRAP_EN defined, opcode F SHALL enter HALT with halted=1 and trap=1, and PC SHALL hold the faulting address; without it, opcode F SHALL execute as NOP and trap SHALL be tied to 0.

Verification
REQ-033 ROM: LDI 5; ST 3; LDI -2; ADD 3; OUT; HALT, with out_ready=1 -> data_out=0x0003 and out_valid for 1 cycle, we pulses once at ram_addr=3, then halted=1.
REQ-034 IN with in_valid low for 4 cycles, then data_in=0x1234 -> in_ready high throughout the wait, acc=0x1234, and PC advances only after the transfer.
REQ-035 OUT with out_ready held low for 5 cycles -> out_valid and data_out stable across all 5 cycles, released the cycle after out_ready=1.
REQ-036 ROM_SIZE=3 with JMP 7 at address 6 followed by NOP at 7 -> PC sequence 6,7,0; JZ with acc=0 taken, JN with acc=0x8000 taken.
REQ-037 rst asserted during an OUT wait and during MEM -> all REQ-029 values on the next edge, and execution restarts at address 0.
REQ-038 Opcode F at address 2 -> trap=1, halted=1, rom_addr=2 with PROC_TRAP_EN defined; executes as NOP, trap=0 without it.
